// File: rtl/gimli_permutation_sequential.sv
// Iterative Gimli-384 permutation: a combinational block of COMBINATIONAL_ROUNDS
// rounds is applied once per clock to a registered state, under a valid/ready FSM.

module gimli_permutation_rounds_combinational #(
  parameter int COMBINATIONAL_ROUNDS = 1
) (
  input  logic [383:0] state_i,
  input  logic [4:0]   round_i,
  output logic [383:0] new_state_o,
  output logic [4:0]   new_round_o,
  output logic         last_round_o
);

  typedef logic [11:0][31:0] gimli_state_t;

  // One Gimli round; rnd is the round number before it is decremented.
  function automatic gimli_state_t gimli_round(input gimli_state_t s_in, input logic [4:0] rnd);
    gimli_state_t s;
    logic [31:0]  x, y, z;
    s = s_in;
    for (int j = 0; j < 4; j++) begin
      x = {s[j][7:0], s[j][31:8]};
      y = {s[4+j][22:0], s[4+j][31:23]};
      z = s[8+j];
      s[8+j] = x ^ {z[30:0], 1'b0} ^ {y[29:0] & z[29:0], 2'b00};
      s[4+j] = y ^ x ^ {x[30:0] | z[30:0], 1'b0};
      s[j]   = z ^ y ^ {x[28:0] & y[28:0], 3'b000};
    end
    case (rnd[1:0])
      2'd0: begin
        s    = {s[11:4], s[2], s[3], s[0], s[1]};
        s[0] = s[0] ^ {24'h9e3779, 3'b000, rnd};
      end
      2'd2:    s = {s[11:4], s[1], s[0], s[3], s[2]};
      default: ;
    endcase
    return s;
  endfunction

  gimli_state_t st;
  logic [4:0]   rnd;

  always_comb begin
    // NOTE: every variable gets a value before the loop so no path infers a latch.
    st  = state_i;
    rnd = round_i;
    for (int k = 0; k < COMBINATIONAL_ROUNDS; k++) begin
      st  = gimli_round(st, rnd);
      rnd = rnd - 5'd1;
    end
    new_state_o = st;
    new_round_o = rnd;
  end

  assign last_round_o = (round_i == 5'(COMBINATIONAL_ROUNDS));

endmodule

module gimli_permutation_sequential #(
  // Must divide 24: 1, 2, 3, 4, 6, 8, 12 or 24.
  parameter int COMBINATIONAL_ROUNDS = 1
) (
  input  logic         clk,
  input  logic         arstn,
  input  logic [383:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic [383:0] dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  fsm_e         fsm_q;
  logic [383:0] state_q, state_d;
  logic [4:0]   round_q, round_d;
  logic         last_round;
  logic         din_ready_q, dout_valid_q, busy_q;

  gimli_permutation_rounds_combinational #(
    .COMBINATIONAL_ROUNDS(COMBINATIONAL_ROUNDS)
  ) u_rounds (
    .state_i     (state_q),
    .round_i     (round_q),
    .new_state_o (state_d),
    .new_round_o (round_d),
    .last_round_o(last_round)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!arstn) begin
      // NOTE: the wide state register is reset too, because dout must read zero after reset.
      fsm_q        <= IDLE;
      state_q      <= '0;
      round_q      <= '0;
      din_ready_q  <= 1'b1;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: if (din_valid) begin
          fsm_q       <= RUN;
          state_q     <= din;
          round_q     <= 5'd24;
          din_ready_q <= 1'b0;
          busy_q      <= 1'b1;
        end
        RUN: begin
          state_q <= state_d;
          round_q <= round_d;
          if (last_round) begin
            fsm_q        <= DONE;
            dout_valid_q <= 1'b1;
          end
        end
        DONE: if (dout_ready) begin
          fsm_q        <= IDLE;
          din_ready_q  <= 1'b1;
          dout_valid_q <= 1'b0;
          busy_q       <= 1'b0;
        end
        default: begin
          fsm_q        <= IDLE;
          din_ready_q  <= 1'b1;
          dout_valid_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign din_ready  = din_ready_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;
  assign dout       = state_q;

endmodule

// File: tb/tb_gimli_permutation_sequential.sv
// Scoreboard bench for gimli_permutation_sequential: a plain-arithmetic Gimli model
// predicts each accepted input; a negedge monitor checks results and latency.

module tb_gimli_permutation_sequential;

  localparam int LAT = 24;
  localparam logic [383:0] KAT_OUT = {
    32'hf41bb8d6, 32'h9e2bef49, 32'h34e52ff7, 32'h84b673f0,
    32'hda5a9cd8, 32'h4f73a0bd, 32'h277a921c, 32'h3eceffea,
    32'hd24c2c68, 32'h380ce880, 32'h91bad119, 32'hba11c85a};

  logic         clk = 1'b0;
  logic         arstn;
  logic [383:0] din;
  logic         din_valid, din_ready, dout_valid, dout_ready, busy;
  logic [383:0] dout;
  logic         din_valid4, din_ready4, dout_valid4, busy4;
  logic [383:0] dout4;
  logic         din_valid24, din_ready24, dout_valid24, busy24;
  logic [383:0] dout24;

  typedef struct {
    logic [383:0] exp;
    int           acc;
  } sb_t;

  sb_t sb_q[$];
  sb_t e;
  int  rise_log[$];
  int  cyc = 0;
  int  n_acc = 0;
  int  last_acc = 0;
  int  n_pass = 0;
  int  n_total = 0;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;

  gimli_permutation_sequential #(.COMBINATIONAL_ROUNDS(1)) dut (
    .clk(clk), .arstn(arstn), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy));

  gimli_permutation_sequential #(.COMBINATIONAL_ROUNDS(4)) dut4 (
    .clk(clk), .arstn(arstn), .din(din), .din_valid(din_valid4), .din_ready(din_ready4),
    .dout(dout4), .dout_valid(dout_valid4), .dout_ready(1'b1), .busy(busy4));

  gimli_permutation_sequential #(.COMBINATIONAL_ROUNDS(24)) dut24 (
    .clk(clk), .arstn(arstn), .din(din), .din_valid(din_valid24), .din_ready(din_ready24),
    .dout(dout24), .dout_valid(dout_valid24), .dout_ready(1'b1), .busy(busy24));

  // Reference Gimli permutation on a 12-word array, rounds 24 down to 1.
  function automatic logic [383:0] gimli_ref(input logic [383:0] in);
    logic [31:0] s[12];
    logic [31:0] x, y, z, t;
    logic [383:0] out;
    for (int i = 0; i < 12; i++) s[i] = in[32*i +: 32];
    for (int r = 24; r > 0; r--) begin
      for (int j = 0; j < 4; j++) begin
        x = (s[j] << 24) | (s[j] >> 8);
        y = (s[4+j] << 9) | (s[4+j] >> 23);
        z = s[8+j];
        s[8+j] = x ^ (z << 1) ^ ((y & z) << 2);
        s[4+j] = y ^ x ^ ((x | z) << 1);
        s[j]   = z ^ y ^ ((x & y) << 3);
      end
      if (r % 4 == 0) begin
        t = s[0]; s[0] = s[1]; s[1] = t;
        t = s[2]; s[2] = s[3]; s[3] = t;
        s[0] = s[0] ^ 32'h9e377900 ^ 32'(r);
      end else if (r % 4 == 2) begin
        t = s[0]; s[0] = s[2]; s[2] = t;
        t = s[1]; s[1] = s[3]; s[3] = t;
      end
    end
    for (int i = 0; i < 12; i++) out[32*i +: 32] = s[i];
    return out;
  endfunction

  function automatic logic [383:0] kat_in();
    logic [383:0] v;
    logic [31:0]  w;
    for (int i = 0; i < 12; i++) begin
      w = 32'(i);
      v[32*i +: 32] = w * w * w + w * 32'h9e3779b9;
    end
    return v;
  endfunction

  function automatic logic [383:0] rand_state();
    logic [383:0] v;
    for (int i = 0; i < 12; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus side of the scoreboard: predict every input the DUT is about to accept.
  always @(negedge clk) begin
    if (!arstn) sb_q.delete();
    else if (din_valid && din_ready) begin
      sb_q.push_back('{exp: gimli_ref(din), acc: cyc + 1});
      n_acc    <= n_acc + 1;
      last_acc <= cyc + 1;
    end
  end

  // Monitor: latency on each dout_valid rise, data on each output handshake.
  always @(negedge clk) begin
    if (arstn) begin
      if (dout_valid && !prev_valid) begin
        rise_log.push_back(cyc);
        if (sb_q.size() == 0) check("dout_valid_unexpected", 1, 0);
        else check("latency", 384'(cyc - sb_q[0].acc), 384'(LAT));
      end
      if (dout_valid && dout_ready && sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("dout_data", dout, e.exp);
      end
    end
    prev_valid <= dout_valid;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_one(input logic [383:0] v);
    int n = 0;
    din       = v;
    din_valid = 1'b1;
    while (!din_ready && n < 100) begin step(); n++; end
    check("send_ready_timeout", din_ready, 1);
    step();
    din_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!dout_valid && n < 100) begin step(); n++; end
    check(name, dout_valid, 1);
  endtask

  task automatic run_small(input string name, input int cr_lat, input bit use24);
    int n = 0;
    din = kat_in();
    if (use24) begin
      check({name, "_ready"}, din_ready24, 1);
      din_valid24 = 1'b1; step(); din_valid24 = 1'b0;
      while (!dout_valid24 && n < 50) begin step(); n++; end
      check({name, "_latency"}, 384'(n), 384'(cr_lat));
      check({name, "_dout"}, dout24, KAT_OUT);
    end else begin
      check({name, "_ready"}, din_ready4, 1);
      din_valid4 = 1'b1; step(); din_valid4 = 1'b0;
      while (!dout_valid4 && n < 50) begin step(); n++; end
      check({name, "_latency"}, 384'(n), 384'(cr_lat));
      check({name, "_dout"}, dout4, KAT_OUT);
    end
    step(2);
  endtask

  initial begin
    logic [383:0] held, v2;
    int n, base, acc0;
    arstn = 1'b0; din = '0; din_valid = 1'b0; dout_ready = 1'b0;
    din_valid4 = 1'b0; din_valid24 = 1'b0;
    step(2);
    check("rst_din_ready", din_ready, 1);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_dout", dout, 0);
    arstn = 1'b1;
    step();

    // Known-answer vector with a single-cycle din_valid.
    send_one(kat_in());
    check("kat_busy", busy, 1);
    wait_valid("kat_timeout");
    check("kat_dout", dout, KAT_OUT);
    dout_ready = 1'b1;
    step(2);

    // Random vectors with random output stalls and ignored din_valid while busy.
    for (int k = 0; k < 8; k++) begin
      dout_ready = 1'b0;
      send_one(rand_state());
      n = 0;
      while (busy && n < 300) begin
        dout_ready = 1'($urandom_range(0, 1));
        din_valid  = 1'($urandom_range(0, 1));
        din        = rand_state();
        step(); n++;
      end
      din_valid = 1'b0;
      check("rand_complete", busy, 0);
      step($urandom_range(0, 2));
    end

    // Output held in DONE while a different input is offered.
    dout_ready = 1'b0;
    send_one(kat_in());
    wait_valid("hold_timeout");
    held = dout;
    v2 = rand_state();
    din = v2; din_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check("hold_dout", dout, held);
      check("hold_din_ready", din_ready, 0);
    end
    dout_ready = 1'b1;
    step();
    check("handshake_din_ready", din_ready, 1);
    check("handshake_dout_valid", dout_valid, 0);
    step();
    din_valid = 1'b0;
    check("new_din_accepted", busy, 1);
    n = 0;
    while (busy && n < 100) begin step(); n++; end

    // Reset in the middle of RUN.
    send_one(rand_state());
    step(9);
    arstn = 1'b0;
    step();
    arstn = 1'b1;
    check("abort_busy", busy, 0);
    check("abort_dout", dout, 0);
    check("abort_dout_valid", dout_valid, 0);
    check("abort_din_ready", din_ready, 1);
    step(30);
    dout_ready = 1'b0;
    send_one(kat_in());
    wait_valid("post_abort_timeout");
    check("post_abort_dout", dout, KAT_OUT);
    dout_ready = 1'b1;
    step(2);

    // Back-to-back with din_valid and dout_ready held high.
    rise_log.delete();
    base = n_acc;
    din = rand_state(); din_valid = 1'b1;
    n = 0;
    while (n_acc < base + 1 && n < 20) begin step(); n++; end
    acc0 = last_acc;
    din = rand_state();
    n = 0;
    while (n_acc < base + 2 && n < 100) begin step(); n++; end
    din_valid = 1'b0;
    n = 0;
    while (rise_log.size() < 2 && n < 100) begin step(); n++; end
    check("b2b_two_results", 384'(rise_log.size()), 2);
    if (rise_log.size() >= 2) begin
      check("b2b_first_edge", 384'(rise_log[0] - acc0), 24);
      check("b2b_second_edge", 384'(rise_log[1] - acc0), 50);
    end
    step(3);

    // Wider round blocks reach the same result with shorter latency.
    run_small("cr4", 6, 1'b0);
    run_small("cr24", 1, 1'b1);

    n = 0;
    while (sb_q.size() != 0 && n < 200) begin step(); n++; end
    check("scoreboard_drained", 384'(sb_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gimli_permutation_sequential.md
GIMLI_PERMUTATION_SEQUENTIAL -- requirements
Module: gimli_permutation_sequential

Interface
REQ-001 SHALL have parameter COMBINATIONAL_ROUNDS, default 1, giving the Gimli rounds evaluated per clock; legal values are 1, 2, 3, 4, 6, 8, 12, 24, and any other value is unsupported.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port arstn, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port din, input, 384 bits: the input state; word i occupies bits [32i+31:32i].
REQ-005 SHALL have port din_valid, input, 1 bit: din is valid.
REQ-006 SHALL have port din_ready, output, 1 bit: the block accepts din.
REQ-007 SHALL have port dout, output, 384 bits: the permuted state, with the same word layout as din.
REQ-008 SHALL have port dout_valid, output, 1 bit: dout holds a finished permutation.
REQ-009 SHALL have port dout_ready, input, 1 bit: the consumer accepts dout.
REQ-010 SHALL have port busy, output, 1 bit: the FSM is not IDLE.

Function
REQ-011 SHALL instantiate one gimli_permutation_rounds_combinational with the same COMBINATIONAL_ROUNDS, fed from the internal 384-bit state register and 5-bit round register.
REQ-012 SHALL implement FSM states IDLE, RUN and DONE, all registered.
REQ-013 SHALL drive din_ready = 1 only in IDLE; dout_valid = 1 only in DONE; busy = 1 in RUN or DONE.
REQ-014 IDLE: on a cycle with din_valid=1 and din_ready=1, SHALL load state_reg<=din and round_reg<=24 and go to RUN.
REQ-015 IDLE without din_valid: SHALL hold all registers.
REQ-016 RUN: each cycle SHALL load state_reg<=new_state and round_reg<=new_round from the instance.
REQ-017 RUN with last_round=1 (round_reg == COMBINATIONAL_ROUNDS) in the same cycle: SHALL go to DONE.
REQ-018 Latency: dout_valid SHALL rise exactly N = 24/COMBINATIONAL_ROUNDS rising edges after the accepting edge (24 for default, 1 for COMBINATIONAL_ROUNDS=24).
REQ-019 DONE: dout SHALL be state_reg and SHALL stay stable until the handshake.
REQ-020 DONE with dout_ready=1: SHALL go to IDLE, so din_ready is 1 on the next cycle; no input is accepted in the handshake cycle itself.
REQ-021 DONE with dout_ready=0: SHALL hold DONE and dout indefinitely.
REQ-022 din_valid asserted in RUN or DONE SHALL be ignored, with no state change and no latching of din.
REQ-023 dout_ready asserted outside DONE SHALL be ignored.
REQ-024 Round arithmetic SHALL be 5-bit unsigned; round_reg never underflows because RUN exits when round_reg == COMBINATIONAL_ROUNDS.
REQ-025 dout outside DONE SHALL be state_reg (intermediate values visible); consumers SHALL qualify dout with dout_valid.

Reset
REQ-026 On a rising edge with arstn=0, SHALL set FSM=IDLE, state_reg=0 and round_reg=0, so that after that edge din_ready=1, dout_valid=0, busy=0 and dout=0.
REQ-027 Reset asserted mid-RUN or in DONE SHALL abort the permutation, discard the result, and produce no dout_valid pulse.
REQ-028 Reset SHALL take priority over every handshake in the same cycle.

Verification
REQ-029 Default parameter, din word i = i*i*i + i*0x9E3779B9 (mod 2^32), i = 0..11, one-cycle din_valid: dout_valid rises 24 edges after acceptance; dout words 0..11 = ba11c85a 91bad119 380ce880 d24c2c68 3eceffea 277a921c 4f73a0bd da5a9cd8 84b673f0 34e52ff7 9e2bef49 f41bb8d6.
REQ-030 Same vector with COMBINATIONAL_ROUNDS=4, then with 24: identical dout; dout_valid after 6 edges and after 1 edge respectively.
REQ-031 Hold dout_ready=0 for 10 cycles in DONE, with din_valid=1 and a different din throughout: dout unchanged, din_ready=0; assert dout_ready -> next cycle IDLE and din_ready=1, after which the new din is accepted.
REQ-032 arstn=0 for one cycle at edge 10 of RUN: busy=0, dout=0, no dout_valid; a fresh vector afterwards produces the REQ-029 result.
REQ-033 Back-to-back: two vectors with din_valid held high and dout_ready held high: results at edges 24 and 50 after the first acceptance (one DONE cycle plus one IDLE cycle between them), both correct.
